// File: rtl/instr_decode.sv
// instr_decode: multi-cycle RV32I decoder (IDLE -> DECODE -> RDREG -> VALID).
// Option DECODE_ILLEGAL_TRAP_EN: flag illegal opcodes and skip the register read.
module instr_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [4:0]  A1,
    output logic [4:0]  A2,
    output logic [4:0]  A3,
    output logic [31:0] imm,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic        rf_rd_en,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic        illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {IDLE, DECODE, RDREG, VALID} state_t;

    state_t      state;
    logic [31:0] instr_q;

    logic [4:0]  d_a1;
    logic [4:0]  d_a2;
    logic [4:0]  d_a3;
    logic [31:0] d_imm;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                    instr_q[30:25], instr_q[11:8], 1'b0};
    assign imm_u = {instr_q[31:12], 12'b0};
    assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                    instr_q[20], instr_q[30:21], 1'b0};

    // Field selection from the held word; registered in DECODE
    always_comb begin
        d_a1  = instr_q[19:15];
        d_a2  = '0;
        d_a3  = instr_q[11:7];
        d_imm = '0;
        case (instr_q[6:0])
            OP_LUI, OP_AUIPC: begin
                d_a1  = '0;
                d_imm = imm_u;
            end
            OP_JAL: begin
                d_a1  = '0;
                d_imm = imm_j;
            end
            OP_JALR, OP_LOAD, OP_IMM: d_imm = imm_i;
            OP_BRANCH: begin
                d_a2  = instr_q[24:20];
                d_a3  = '0;
                d_imm = imm_b;
            end
            OP_STORE: begin
                d_a2  = instr_q[24:20];
                d_a3  = '0;
                d_imm = imm_s;
            end
            OP_REG:   d_a2 = instr_q[24:20];
            OP_FENCE: d_a3 = '0;
            default: ;
        endcase
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic d_legal;

    always_comb begin
        d_legal = instr_q[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
                                       OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM,
                                       OP_REG, OP_FENCE, OP_SYSTEM};
    end
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            instr_q     <= '0;
            instr_ready <= 1'b1;
            rf_rd_en    <= 1'b0;
            dec_valid   <= 1'b0;
            A1          <= '0;
            A2          <= '0;
            A3          <= '0;
            imm         <= '0;
            opcode      <= '0;
            funct3      <= '0;
            funct7      <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal     <= 1'b0;
`endif
        end else if (flush) begin
            // Abort only the control path; decoded fields keep their values
            state       <= IDLE;
            instr_ready <= 1'b1;
            rf_rd_en    <= 1'b0;
            dec_valid   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (instr_valid) begin
                        instr_q     <= instr;
                        instr_ready <= 1'b0;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    A1     <= d_a1;
                    A2     <= d_a2;
                    A3     <= d_a3;
                    imm    <= d_imm;
                    opcode <= instr_q[6:0];
                    funct3 <= instr_q[14:12];
                    funct7 <= instr_q[31:25];
`ifdef DECODE_ILLEGAL_TRAP_EN
                    illegal <= !d_legal;
                    if (!d_legal) begin
                        dec_valid <= 1'b1;
                        state     <= VALID;
                    end else begin
                        rf_rd_en <= 1'b1;
                        state    <= RDREG;
                    end
`else
                    rf_rd_en <= 1'b1;
                    state    <= RDREG;
`endif
                end
                RDREG: begin
                    rf_rd_en  <= 1'b0;
                    dec_valid <= 1'b1;
                    state     <= VALID;
                end
                VALID: begin
                    if (dec_ready) begin
                        dec_valid   <= 1'b0;
                        instr_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_decode.sv
// tb_instr_decode: vector table, random legal instructions vs. a field model,
// plus hand-written reset/flush/stall sequences.
module tb_instr_decode;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [4:0]  A3;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        rf_rd_en;
    logic        dec_valid;
    logic        dec_ready;
    logic        illegal;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_decode dut (
        .clk(clk), .reset(reset), .flush(flush),
        .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready),
        .A1(A1), .A2(A2), .A3(A3), .imm(imm),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rf_rd_en(rf_rd_en), .dec_valid(dec_valid),
        .dec_ready(dec_ready), .illegal(illegal)
    );

    typedef struct {
        logic [31:0] w;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic        ill;
    } vec_t;

    logic [6:0] legal_ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                                   7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    function automatic vec_t mk(input logic [31:0] w, input int a1, input int a2,
                                input int a3, input logic [31:0] im,
                                input int f3, input bit legal);
        vec_t v;
        v.w = w;
        v.a1 = 5'(a1);
        v.a2 = 5'(a2);
        v.a3 = 5'(a3);
        v.imm = im;
        v.f3 = 3'(f3);
        v.ill = TRAP && !legal;
        return v;
    endfunction

    // Reference: expected fields from the ISA immediate rules, via arithmetic
    function automatic vec_t model(input logic [31:0] w);
        vec_t v;
        int signed s;
        int signed sgn;
        string fmt;
        logic [6:0] op;
        bit legal;
        s = int'(w);
        sgn = s >>> 31;
        op = w[6:0];
        legal = 1'b0;
        foreach (legal_ops[k]) if (legal_ops[k] == op) legal = 1'b1;
        case (op)
            7'h03, 7'h13, 7'h67: fmt = "I";
            7'h23: fmt = "S";
            7'h63: fmt = "B";
            7'h37, 7'h17: fmt = "U";
            7'h6F: fmt = "J";
            default: fmt = "-";
        endcase
        case (fmt)
            "I": v.imm = 32'(s >>> 20);
            "S": v.imm = 32'((s >>> 25) * 32 + int'(w[11:7]));
            "B": v.imm = 32'(sgn * 4096 + int'(w[7]) * 2048
                             + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
            "U": v.imm = w & 32'hFFFF_F000;
            "J": v.imm = 32'(sgn * 1048576 + int'(w[19:12]) * 4096
                             + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
            default: v.imm = 32'd0;
        endcase
        v.w = w;
        v.a1 = (op == 7'h37 || op == 7'h17 || op == 7'h6F) ? 5'd0 : w[19:15];
        v.a2 = (op == 7'h33 || op == 7'h23 || op == 7'h63) ? w[24:20] : 5'd0;
        v.a3 = (op == 7'h63 || op == 7'h23 || op == 7'h0F) ? 5'd0 : w[11:7];
        v.f3 = w[14:12];
        v.ill = TRAP && !legal;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_fields(input string tag, input vec_t e);
        check({tag, ".A1"}, 32'(A1), 32'(e.a1));
        check({tag, ".A2"}, 32'(A2), 32'(e.a2));
        check({tag, ".A3"}, 32'(A3), 32'(e.a3));
        check({tag, ".imm"}, imm, e.imm);
        check({tag, ".opcode"}, 32'(opcode), 32'(e.w[6:0]));
        check({tag, ".funct3"}, 32'(funct3), 32'(e.f3));
        check({tag, ".funct7"}, 32'(funct7), 32'(e.w[31:25]));
        check({tag, ".illegal"}, 32'(illegal), 32'(e.ill));
    endtask

    int acc_cyc;

    // One full transaction, starting and ending at a negedge in IDLE
    task automatic run_instr(input string tag, input vec_t e, input int dly,
                             input bit early);
        int rf_cnt;
        rf_cnt = 0;
        check({tag, ".ready_idle"}, 32'(instr_ready), 32'd1);
        acc_cyc = cyc;
        instr_valid = 1'b1;
        instr = e.w;
        if (early) dec_ready = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr = $urandom;
        rf_cnt += int'(rf_rd_en);
        check({tag, ".dv_c1"}, 32'(dec_valid), 32'd0);
        check({tag, ".ready_c1"}, 32'(instr_ready), 32'd0);
        @(negedge clk);
        rf_cnt += int'(rf_rd_en);
        check_fields(tag, e);
        if (e.ill) begin
            check({tag, ".dv_c2"}, 32'(dec_valid), 32'd1);
        end else begin
            check({tag, ".dv_c2"}, 32'(dec_valid), 32'd0);
            @(negedge clk);
            rf_cnt += int'(rf_rd_en);
            check({tag, ".dv_c3"}, 32'(dec_valid), 32'd1);
        end
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            rf_cnt += int'(rf_rd_en);
            check({tag, ".dv_hold"}, 32'(dec_valid), 32'd1);
            check({tag, ".ready_hold"}, 32'(instr_ready), 32'd0);
            check_fields({tag, ".hold"}, e);
        end
        dec_ready = 1'b1;
        @(negedge clk);
        rf_cnt += int'(rf_rd_en);
        dec_ready = 1'b0;
        check({tag, ".dv_done"}, 32'(dec_valid), 32'd0);
        check({tag, ".ready_done"}, 32'(instr_ready), 32'd1);
        check({tag, ".rf_pulses"}, 32'(rf_cnt), e.ill ? 32'd0 : 32'd1);
    endtask

    vec_t tbl [12];
    vec_t zero_v;
    vec_t prev;
    vec_t cur;

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        instr_valid = 1'b0;
        instr = '0;
        dec_ready = 1'b0;
        zero_v = mk(32'h0, 0, 0, 0, 32'h0, 0, 1'b1);

        tbl[0]  = mk(32'h01008293, 1, 0, 5, 32'h0000_0010, 0, 1'b1);
        tbl[1]  = mk(32'hFE21AE23, 3, 2, 0, 32'hFFFF_FFFC, 2, 1'b1);
        tbl[2]  = mk(32'h123453B7, 0, 0, 7, 32'h1234_5000, 5, 1'b1);
        tbl[3]  = mk(32'h002081B3, 1, 2, 3, 32'h0000_0000, 0, 1'b1);
        tbl[4]  = mk(32'hFE208CE3, 1, 2, 0, 32'hFFFF_FFF8, 0, 1'b1);
        tbl[5]  = mk(32'hFFDFF0EF, 0, 0, 1, 32'hFFFF_FFFC, 7, 1'b1);
        tbl[6]  = mk(32'hFFFFF517, 0, 0, 10, 32'hFFFF_F000, 7, 1'b1);
        tbl[7]  = mk(32'hFFF12303, 2, 0, 6, 32'hFFFF_FFFF, 2, 1'b1);
        tbl[8]  = mk(32'h00008067, 1, 0, 0, 32'h0000_0000, 0, 1'b1);
        tbl[9]  = mk(32'h305312F3, 6, 0, 5, 32'h0000_0000, 1, 1'b1);
        tbl[10] = mk(32'h0FF0028F, 0, 0, 0, 32'h0000_0000, 0, 1'b1);
        tbl[11] = mk(32'h00000000, 0, 0, 0, 32'h0000_0000, 0, 1'b0);

        @(negedge clk);
        check("rst.instr_ready", 32'(instr_ready), 32'd1);
        check("rst.rf_rd_en", 32'(rf_rd_en), 32'd0);
        check("rst.dec_valid", 32'(dec_valid), 32'd0);
        check_fields("rst", zero_v);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            int last;
            last = acc_cyc;
            run_instr($sformatf("tbl%0d", i), tbl[i], 0, 1'b0);
            if (i > 0 && !tbl[i-1].ill)
                check($sformatf("tbl%0d.spacing", i), 32'(acc_cyc - last), 32'd4);
        end

        run_instr("stall5", tbl[0], 5, 1'b0);
        run_instr("early_ready", tbl[3], 0, 1'b1);

        // Flush in DECODE: previous fields must survive
        prev = tbl[3];
        instr_valid = 1'b1;
        instr = tbl[1].w;
        @(negedge clk);
        instr_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_dec.instr_ready", 32'(instr_ready), 32'd1);
        check("fl_dec.rf_rd_en", 32'(rf_rd_en), 32'd0);
        check("fl_dec.dec_valid", 32'(dec_valid), 32'd0);
        check_fields("fl_dec", prev);

        // Flush in RDREG
        instr_valid = 1'b1;
        instr = tbl[2].w;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check("fl_rd.in_rdreg", 32'(rf_rd_en), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_rd.instr_ready", 32'(instr_ready), 32'd1);
        check("fl_rd.rf_rd_en", 32'(rf_rd_en), 32'd0);
        check("fl_rd.dec_valid", 32'(dec_valid), 32'd0);
        check_fields("fl_rd", tbl[2]);
        repeat (3) begin
            @(negedge clk);
            check("fl_rd.no_dv", 32'(dec_valid), 32'd0);
        end

        // Flush together with instr_valid in IDLE: no acceptance
        instr_valid = 1'b1;
        flush = 1'b1;
        instr = tbl[0].w;
        @(negedge clk);
        instr_valid = 1'b0;
        flush = 1'b0;
        check("fl_idle.instr_ready", 32'(instr_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("fl_idle.no_rf", 32'(rf_rd_en), 32'd0);
            check("fl_idle.no_dv", 32'(dec_valid), 32'd0);
        end

        // Reset in RDREG: immediate clear, nothing follows
        instr_valid = 1'b1;
        instr = tbl[1].w;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check("rst_rd.in_rdreg", 32'(rf_rd_en), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_rd.instr_ready", 32'(instr_ready), 32'd1);
        check("rst_rd.rf_rd_en", 32'(rf_rd_en), 32'd0);
        check("rst_rd.dec_valid", 32'(dec_valid), 32'd0);
        check_fields("rst_rd", zero_v);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst_rd.idle", 32'(instr_ready), 32'd1);
            check("rst_rd.no_rf", 32'(rf_rd_en), 32'd0);
            check("rst_rd.no_dv", 32'(dec_valid), 32'd0);
        end

        // Random legal instructions against the model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] r;
            r = $urandom;
            cur = model({r[31:7], legal_ops[$urandom_range(0, 10)]});
            run_instr($sformatf("rnd%0d", i), cur, $urandom_range(0, 3), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
